// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, symmetric debounce FSM,
// press/release/long-press event pulses and a saturating press counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned LONG_CYCLES     = 32
) (
    input  logic       clk2,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam logic [15:0] DEB_MAX  = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] LONG_MAX = 16'(LONG_CYCLES);

    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    state_t      state;
    logic        sync1, sync2;
    logic [15:0] deb_cnt;
    logic [15:0] hold_cnt;
    logic        rel_accept;
    logic        hold_run;

    // The release edge itself does not advance hold_cnt, so long_press can
    // never coincide with release_pulse.
    assign rel_accept = (state == WAIT_LOW) && !sync2 && (deb_cnt >= DEB_MAX);
    assign hold_run   = (state == HIGH) || ((state == WAIT_LOW) && !rel_accept);

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state         <= LOW;
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= '0;
        end else begin
            sync1         <= btn_in;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            case (state)
                LOW: begin
                    if (sync2) begin
                        state   <= WAIT_HIGH;
                        deb_cnt <= 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2) begin
                        state   <= LOW;
                        deb_cnt <= '0;
                    end else if (deb_cnt >= DEB_MAX) begin
                        state       <= HIGH;
                        deb_cnt     <= '0;
                        hold_cnt    <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        if (press_count != 8'hFF)
                            press_count <= press_count + 8'd1;
                    end else begin
                        deb_cnt <= deb_cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (!sync2) begin
                        state   <= WAIT_LOW;
                        deb_cnt <= 16'd1;
                    end
                end
                WAIT_LOW: begin
                    // A glitch back to HIGH keeps hold_cnt, so one press yields one long_press.
                    if (sync2) begin
                        state   <= HIGH;
                        deb_cnt <= '0;
                    end else if (rel_accept) begin
                        state         <= LOW;
                        deb_cnt       <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 16'd1;
                    end
                end
                default: state <= LOW;
            endcase

            if (hold_run && (hold_cnt < LONG_MAX)) begin
                hold_cnt <= hold_cnt + 16'd1;
                if (hold_cnt == LONG_MAX - 16'd1)
                    long_press <= 1'b1;
            end
        end
    end

endmodule
